// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB fade sequencer.
// Optional build macro: RGB_FADE_GAMMA_EN (squared-intensity output stage).
package rgb_pkg;

    localparam int unsigned CHAN_W = 8;

    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } rgb_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FADE = 1'b1
    } fade_state_e;

    // True when a and b differ by exactly one LSB, i.e. one step closes the gap.
    function automatic logic one_apart(input logic [CHAN_W-1:0] a, input logic [CHAN_W-1:0] b);
        logic [CHAN_W:0] a_ext;
        logic [CHAN_W:0] b_ext;
        a_ext = (CHAN_W+1)'(a);
        b_ext = (CHAN_W+1)'(b);
        return ((a_ext + (CHAN_W+1)'(1)) == b_ext) || ((b_ext + (CHAN_W+1)'(1)) == a_ext);
    endfunction

    // Perceptual curve: upper byte of the 16-bit square.
    function automatic logic [CHAN_W-1:0] gamma8(input logic [CHAN_W-1:0] v);
        logic [2*CHAN_W-1:0] prod;
        prod = (2*CHAN_W)'(v) * (2*CHAN_W)'(v);
        return prod[2*CHAN_W-1:CHAN_W];
    endfunction

endpackage

// File: rtl/fade_channel.sv
// One colour channel: direct load or a single saturating step toward target.
module fade_channel
    import rgb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [CHAN_W-1:0] target,
    output logic [CHAN_W-1:0] value,
    output logic              eq
);

    logic [CHAN_W-1:0] r_value;

    // Channel intensity: load wins over step; steps only move toward target so never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= target;
        end else if (step) begin
            if (r_value < target) begin
                r_value <= r_value + CHAN_W'(1);
            end else if (r_value > target) begin
                r_value <= r_value - CHAN_W'(1);
            end
        end
    end

    assign value = r_value;
    assign eq    = (r_value == target);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Linear RGB fade engine feeding the PWM stage.
// Optional build macro: RGB_FADE_GAMMA_EN adds a registered squared-output stage.
module rgb_fade_sequencer
    import rgb_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned TICK_W   = 17
) (
    input  logic        GCLK,
    input  logic        RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [23:0] CMD_RGB,
    input  logic [7:0]  CMD_RATE,
    output logic [7:0]  RED_O,
    output logic [7:0]  GREEN_O,
    output logic [7:0]  BLUE_O,
    output logic        BUSY_O,
    output logic        DONE_O
);

    fade_state_e       r_state;
    fade_state_e       w_state_nxt;
    logic [TICK_W-1:0] r_presc;
    logic              w_tick;
    rgb_t              r_target;
    logic [7:0]        r_rate;
    logic [7:0]        r_rate_cnt;
    logic [7:0]        w_rate_cnt_nxt;
    logic              r_busy;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_xfer;
    logic              w_load;
    logic              w_step;
    logic              w_all_hit;
    rgb_t              w_cur;
    rgb_t              w_chan_tgt;
    logic [2:0]        w_eq;

    assign w_tick    = (r_presc == TICK_W'(TICK_DIV - 1));
    assign CMD_READY = (r_state == IDLE);
    assign w_xfer    = CMD_VALID && CMD_READY;

    // During a transfer the channels see the incoming colour so a jump can load it directly.
    assign w_chan_tgt = w_xfer ? rgb_t'(CMD_RGB) : r_target;

    // Every channel lands on target after this step (already equal or one LSB away).
    assign w_all_hit = (w_eq[2] || one_apart(w_cur.r, r_target.r))
                    && (w_eq[1] || one_apart(w_cur.g, r_target.g))
                    && (w_eq[0] || one_apart(w_cur.b, r_target.b));

    fade_channel u_chan_r (
        .clk(GCLK), .rst(RST), .load(w_load), .step(w_step),
        .target(w_chan_tgt.r), .value(w_cur.r), .eq(w_eq[2])
    );
    fade_channel u_chan_g (
        .clk(GCLK), .rst(RST), .load(w_load), .step(w_step),
        .target(w_chan_tgt.g), .value(w_cur.g), .eq(w_eq[1])
    );
    fade_channel u_chan_b (
        .clk(GCLK), .rst(RST), .load(w_load), .step(w_step),
        .target(w_chan_tgt.b), .value(w_cur.b), .eq(w_eq[0])
    );

    // Next-state, rate divider and step/load decisions.
    always_comb begin
        w_state_nxt    = r_state;
        w_rate_cnt_nxt = r_rate_cnt;
        w_load         = 1'b0;
        w_step         = 1'b0;
        w_done_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    if ((CMD_RATE == 8'd0) || (CMD_RGB == w_cur)) begin
                        w_load     = 1'b1;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = FADE;
                        w_rate_cnt_nxt = 8'd0;
                    end
                end
            end
            FADE: begin
                if (w_tick) begin
                    if (r_rate_cnt == (r_rate - 8'd1)) begin
                        w_step         = 1'b1;
                        w_rate_cnt_nxt = 8'd0;
                        if (w_all_hit) begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_rate_cnt_nxt = r_rate_cnt + 8'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, prescaler, command latch and status flags.
    always_ff @(posedge GCLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_presc    <= '0;
            r_rate_cnt <= 8'd0;
            r_rate     <= 8'd0;
            r_target   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_tick ? '0 : (r_presc + TICK_W'(1));
            r_rate_cnt <= w_rate_cnt_nxt;
            r_busy     <= (w_state_nxt == FADE);
            r_done     <= w_done_nxt;
            if (w_xfer) begin
                r_target <= rgb_t'(CMD_RGB);
                r_rate   <= CMD_RATE;
            end
        end
    end

    assign BUSY_O = r_busy;

`ifdef RGB_FADE_GAMMA_EN
    logic [7:0] r_red;
    logic [7:0] r_grn;
    logic [7:0] r_blu;
    logic       r_done_d;

    // Squared output stage; DONE is delayed to stay aligned with it.
    always_ff @(posedge GCLK) begin
        if (RST) begin
            r_red    <= 8'd0;
            r_grn    <= 8'd0;
            r_blu    <= 8'd0;
            r_done_d <= 1'b0;
        end else begin
            r_red    <= gamma8(w_cur.r);
            r_grn    <= gamma8(w_cur.g);
            r_blu    <= gamma8(w_cur.b);
            r_done_d <= r_done;
        end
    end

    assign RED_O   = r_red;
    assign GREEN_O = r_grn;
    assign BLUE_O  = r_blu;
    assign DONE_O  = r_done_d;
`else
    assign RED_O   = w_cur.r;
    assign GREEN_O = w_cur.g;
    assign BLUE_O  = w_cur.b;
    assign DONE_O  = r_done;
`endif

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed self-checking bench for rgb_fade_sequencer (TICK_DIV = 4).
module tb_rgb_fade_sequencer;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned TICK_W   = 3;
`ifdef RGB_FADE_GAMMA_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        GCLK = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [23:0] CMD_RGB = 24'h0;
    logic [7:0]  CMD_RATE = 8'h0;
    logic [7:0]  RED_O;
    logic [7:0]  GREEN_O;
    logic [7:0]  BLUE_O;
    logic        BUSY_O;
    logic        DONE_O;

    int n_checks = 0;
    int n_errors = 0;

    rgb_fade_sequencer #(.TICK_DIV(TICK_DIV), .TICK_W(TICK_W)) dut (
        .GCLK(GCLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_RGB(CMD_RGB), .CMD_RATE(CMD_RATE), .RED_O(RED_O), .GREEN_O(GREEN_O),
        .BLUE_O(BLUE_O), .BUSY_O(BUSY_O), .DONE_O(DONE_O)
    );

    always #5 GCLK = ~GCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge GCLK);
        #1;
    endtask

    function automatic logic [7:0] out_of(input logic [7:0] v);
`ifdef RGB_FADE_GAMMA_EN
        logic [15:0] p;
        p = 16'(v) * 16'(v);
        return p[15:8];
`else
        return v;
`endif
    endfunction

    function automatic logic [7:0] toward(input logic [7:0] c, input logic [7:0] t);
        if (c < t) return c + 8'd1;
        if (c > t) return c - 8'd1;
        return c;
    endfunction

    function automatic int absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
    endfunction

    // Jump command: expect expanded output and one DONE pulse LAT cycles after the transfer edge.
    task automatic jump(input string tag, input logic [23:0] rgb, input logic [7:0] rate);
        logic [23:0] expv;
        expv = {out_of(rgb[23:16]), out_of(rgb[15:8]), out_of(rgb[7:0])};
        CMD_RGB = rgb; CMD_RATE = rate; CMD_VALID = 1'b1;
        cyc();
        CMD_VALID = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            check({tag, "_done_early"}, 32'(DONE_O), 32'd0);
            cyc();
        end
        check({tag, "_rgb"},   32'({RED_O, GREEN_O, BLUE_O}), 32'(expv));
        check({tag, "_done"},  32'(DONE_O), 32'd1);
        check({tag, "_busy"},  32'(BUSY_O), 32'd0);
        check({tag, "_ready"}, 32'(CMD_READY), 32'd1);
        cyc();
        check({tag, "_done_off"}, 32'(DONE_O), 32'd0);
    endtask

    // Follow a fade after its transfer edge against a per-step model until DONE.
    task automatic watch_fade(input string tag, input logic [23:0] start, input logic [23:0] tgt,
                              input int rate, input int busy_before, input bit ready_low);
        logic [23:0] cur, prev, o;
        int cycn, last, nsteps, busy_cyc, ready_bad, exp_steps, lo, hi;
        bit  done_seen;
        cur = start; prev = start; cycn = 0; last = 0; nsteps = 0;
        busy_cyc = busy_before; ready_bad = 0; done_seen = 0;
        exp_steps = absdiff(tgt[23:16], start[23:16]);
        if (absdiff(tgt[15:8], start[15:8]) > exp_steps) exp_steps = absdiff(tgt[15:8], start[15:8]);
        if (absdiff(tgt[7:0], start[7:0]) > exp_steps) exp_steps = absdiff(tgt[7:0], start[7:0]);
        while (!done_seen && cycn < 2000) begin
            cyc();
            cycn++;
            o = {RED_O, GREEN_O, BLUE_O};
            if (o != prev) begin
                cur = {toward(cur[23:16], tgt[23:16]), toward(cur[15:8], tgt[15:8]), toward(cur[7:0], tgt[7:0])};
                check({tag, "_step_val"}, 32'(o), 32'(cur));
                if (nsteps > 0) check({tag, "_step_gap"}, 32'(cycn - last), 32'(rate * int'(TICK_DIV)));
                last = cycn;
                nsteps++;
                prev = o;
            end
            if (BUSY_O) begin
                busy_cyc++;
                if (ready_low && CMD_READY) ready_bad++;
            end
            if (DONE_O) begin
                done_seen = 1;
                check({tag, "_done_rgb"},   32'(o), 32'(tgt));
                check({tag, "_done_busy"},  32'(BUSY_O), 32'd0);
                check({tag, "_done_ready"}, 32'(CMD_READY), 32'd1);
                check({tag, "_done_step"},  32'(cycn), 32'(last));
            end
        end
        check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        check({tag, "_nsteps"}, 32'(nsteps), 32'(exp_steps));
        if (ready_low) check({tag, "_ready_low"}, 32'(ready_bad), 32'd0);
        lo = (exp_steps - 1) * rate * int'(TICK_DIV) + (rate - 1) * int'(TICK_DIV) + 1;
        hi = exp_steps * rate * int'(TICK_DIV);
        check({tag, "_busy_len"}, 32'((busy_cyc >= lo) && (busy_cyc <= hi)), 32'd1);
    endtask

    initial begin
        // 1: reset for three cycles
        RST = 1'b1;
        repeat (3) cyc();
        RST = 1'b0;
        check("rst_rgb",   32'({RED_O, GREEN_O, BLUE_O}), 32'h0);
        check("rst_busy",  32'(BUSY_O), 32'd0);
        check("rst_done",  32'(DONE_O), 32'd0);
        check("rst_ready", 32'(CMD_READY), 32'd1);

        // Equal-to-current with non-zero rate completes as a jump
        jump("same", 24'h000000, 8'd5);

`ifndef RGB_FADE_GAMMA_EN
        // 2: slow ramp at rate 1
        CMD_RGB = 24'h030100; CMD_RATE = 8'd1; CMD_VALID = 1'b1;
        cyc();
        CMD_VALID = 1'b0;
        check("f2_busy_start", 32'(BUSY_O), 32'd1);
        check("f2_ready_low",  32'(CMD_READY), 32'd0);
        watch_fade("f2", 24'h000000, 24'h030100, 1, 1, 1'b0);
`endif

        // 3: immediate jump
        jump("jump", 24'hFF00FF, 8'd0);

`ifndef RGB_FADE_GAMMA_EN
        // 4: fade with a held command accepted in the DONE cycle
        jump("to0", 24'h000000, 8'd0);
        CMD_RGB = 24'h050505; CMD_RATE = 8'd2; CMD_VALID = 1'b1;
        cyc();
        CMD_RGB = 24'h000000; CMD_RATE = 8'd2;
        check("f4_busy_start", 32'(BUSY_O), 32'd1);
        watch_fade("f4up", 24'h000000, 24'h050505, 2, 1, 1'b1);
        cyc();
        CMD_VALID = 1'b0;
        check("f4_b2b_busy", 32'(BUSY_O), 32'd1);
        check("f4_b2b_rgb",  32'({RED_O, GREEN_O, BLUE_O}), 32'h050505);
        watch_fade("f4dn", 24'h050505, 24'h000000, 2, 1, 1'b0);

        // 5: reset in the middle of a fade
        CMD_RGB = 24'h808080; CMD_RATE = 8'd1; CMD_VALID = 1'b1;
        cyc();
        CMD_VALID = 1'b0;
        begin
            int waited;
            waited = 0;
            while (RED_O != 8'h40 && waited < 400) begin
                cyc();
                waited++;
            end
            check("f5_reach40", 32'(RED_O), 32'h40);
        end
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        check("f5_rst_rgb",   32'({RED_O, GREEN_O, BLUE_O}), 32'h0);
        check("f5_rst_busy",  32'(BUSY_O), 32'd0);
        check("f5_rst_ready", 32'(CMD_READY), 32'd1);
        repeat (20) cyc();
        check("f5_no_resume_rgb",  32'({RED_O, GREEN_O, BLUE_O}), 32'h0);
        check("f5_no_resume_busy", 32'(BUSY_O), 32'd0);
`endif

        // Reset coincident with a transfer: reset wins
        jump("pre", 24'h112233, 8'd0);
        RST = 1'b1; CMD_RGB = 24'h123456; CMD_RATE = 8'd0; CMD_VALID = 1'b1;
        cyc();
        RST = 1'b0; CMD_VALID = 1'b0;
        repeat (2) cyc();
        check("rstx_rgb",  32'({RED_O, GREEN_O, BLUE_O}), 32'h0);
        check("rstx_done", 32'(DONE_O), 32'd0);
        check("rstx_busy", 32'(BUSY_O), 32'd0);

        // 6: jump whose gamma image is 0xFE/0x40/0x01
        jump("g6", 24'hFF8010, 8'd0);
        jump("g6b", 24'h0F0F0F, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rgb_fade_sequencer.md
Name: rgb_fade_sequencer

Overview:
- Upstream colour source for the RGB PWM stage. It accepts colour commands over a valid/ready handshake: a 24-bit target colour plus a fade rate.
- It ramps its registered 8-bit red/green/blue intensities linearly from the current colour to the target, one LSB per step per channel.
- The PWM stage consumes RED_O/GREEN_O/BLUE_O directly as duty values.

Parameters:
- TICK_DIV, 100000: GCLK cycles per fade tick (1 ms at 100 MHz); must be >= 2.
- TICK_W, 17: width of the tick prescaler counter; must satisfy 2^TICK_W >= TICK_DIV.

Ports:
- GCLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  block can accept a command.
- CMD_RGB  in  24  target colour {R[23:16], G[15:8], B[7:0]}.
- CMD_RATE  in  8  ticks per unit step; 0 = jump immediately.
- RED_O  out  8  current red intensity (registered).
- GREEN_O  out  8  current green intensity (registered).
- BLUE_O  out  8  current blue intensity (registered).
- BUSY_O  out  1  fade in progress.
- DONE_O  out  1  one-cycle pulse when the target is reached.

Behaviour:
- Reset (RST=1 at an edge) clears all of the following; a command in flight is discarded:
  - state = IDLE
  - prescaler = 0, rate_cnt = 0
  - current R/G/B = 0, target = 0
  - RED_O/GREEN_O/BLUE_O = 0, BUSY_O = 0, DONE_O = 0
- Prescaler:
  - Free-running 0..TICK_DIV-1.
  - tick = 1 for the single cycle in which prescaler == TICK_DIV-1; the prescaler wraps to 0 on the next edge.
- CMD_READY = (state == IDLE); it is combinational from the state register. A transfer occurs at an edge where CMD_VALID && CMD_READY.
- On transfer:
  - Latch target = CMD_RGB and rate = CMD_RATE.
  - If CMD_RATE == 0 or CMD_RGB == current: load current = target at the same edge, set DONE_O = 1 for the next cycle, and stay in IDLE. BUSY_O stays 0.
  - Otherwise: go to FADE, set rate_cnt = 0, BUSY_O = 1.
- FADE:
  - On each tick:
    - If rate_cnt == rate-1: step and set rate_cnt = 0.
    - Else: rate_cnt++.
  - Step, per channel: current +1 if below target, -1 if above, unchanged if equal. The +1/-1 never wraps.
  - At the edge where the post-step values all equal target: go to IDLE, BUSY_O = 0, DONE_O = 1 for exactly one cycle.
  - Ticks outside FADE do not touch rate_cnt.
- Outputs:
  - RED_O/GREEN_O/BLUE_O equal the current registers. No added latency without the optional feature.
  - A fade from c to t completes in max(|t-c|) × rate ticks.
- CMD_VALID during FADE is ignored (not lost): the command is held by the source and accepted in the first IDLE cycle. That is the cycle in which DONE_O = 1, so a back-to-back transfer is legal.
- Simultaneous RST and transfer: reset wins; no command is taken.

Optional Feature:
- Macro: RGB_FADE_GAMMA_EN.
- Defined:
  - Each output = (current × current) >> 8, computed with a 16-bit product, upper byte taken.
  - Registered, so outputs lag the current registers by one extra cycle; DONE_O is delayed one cycle to stay aligned.
  - Example values: 255→254, 128→64, 16→1, 15→0.
  - Reset value of the outputs is 0.
- Undefined: linear outputs as above, no extra stage.

Decomposition:
- Package rgb_pkg:
  - Typedef rgb_t (struct of three 8-bit channels r, g, b).
  - State enum {IDLE, FADE}.
  - Constant CHAN_W = 8.
- Sub-module fade_channel, instantiated 3×:
  - Inputs: clk, rst, load, step, target[7:0].
  - Outputs: value[7:0] and eq (value == target).
  - Implements the ±1 saturating step and the load.
- Prescaler, rate counter and FSM stay in the top level.

Test Plan (TICK_DIV=4):
1. Assert RST for 3 cycles, then release -> RED_O/GREEN_O/BLUE_O = 0, BUSY_O = 0, DONE_O = 0, CMD_READY = 1.
2. From 0, send CMD_RGB=0x030100, CMD_RATE=1 -> on successive ticks R=1,2,3 and G=1,1,1, B stays 0; BUSY_O high ~12 cycles; DONE_O pulses once, coincident with R reaching 3.
3. Send CMD_RGB=0xFF00FF, CMD_RATE=0 -> outputs FF/00/FF the next cycle; DONE_O = 1 for 1 cycle; BUSY_O never rises; CMD_READY stays 1.
4. During a fade from 0x000000 to 0x050505 at rate 2, hold CMD_VALID with 0x000000 -> CMD_READY = 0 throughout; the new command is accepted in the DONE_O cycle; the ramp then decrements 5→0, one step every 2 ticks.
5. Assert RST mid-fade at R=0x40 -> next cycle all outputs 0, state IDLE, CMD_READY = 1; the pending target is not resumed.
6. With RGB_FADE_GAMMA_EN, jump to 0xFF8010 at rate 0 -> two cycles later RED_O=0xFE, GREEN_O=0x40, BLUE_O=0x01; DONE_O is aligned with that cycle.
